// File: rtl/axil_csr_pkg.sv
// Shared response codes, decode classes and byte-merge helper for the AXI-Lite CSR responder.
package axil_csr_pkg;

  localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_gp = 2'b10;

  typedef enum logic [1:0] {
    e_csr_rw,
    e_csr_ro,
    e_csr_unmapped
  } axil_csr_decode_e;

  function automatic logic [31:0] csr_byte_merge(input logic [31:0] old_i,
                                                 input logic [31:0] new_i,
                                                 input logic [3:0]  strb_i);
    logic [31:0] res;
    res = old_i;
    for (int b = 0; b < 4; b++) begin
      if (strb_i[b]) res[b*8 +: 8] = new_i[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_csr_responder.sv
// AXI4-Lite responder exposing RW control registers and RO status words.
// Write (AW/W/B) and read (AR/R) paths are independent, one outstanding transaction each.
module axil_csr_responder
  import axil_csr_pkg::*;
#(
  parameter int addr_width_p  = 10,
  parameter int data_width_p  = 32,
  parameter int num_rw_regs_p = 4,
  parameter int num_ro_regs_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [addr_width_p-1:0]                awaddr_i,
  input  logic [2:0]                             awprot_i,
  input  logic                                   awvalid_i,
  output logic                                   awready_o,
  input  logic [data_width_p-1:0]                wdata_i,
  input  logic [data_width_p/8-1:0]              wstrb_i,
  input  logic                                   wvalid_i,
  output logic                                   wready_o,
  output logic [1:0]                             bresp_o,
  output logic                                   bvalid_o,
  input  logic                                   bready_i,
  input  logic [addr_width_p-1:0]                araddr_i,
  input  logic [2:0]                             arprot_i,
  input  logic                                   arvalid_i,
  output logic                                   arready_o,
  output logic [data_width_p-1:0]                rdata_o,
  output logic [1:0]                             rresp_o,
  output logic                                   rvalid_o,
  input  logic                                   rready_i,
  output logic [num_rw_regs_p*data_width_p-1:0]  rw_data_o,
  output logic [num_rw_regs_p-1:0]               rw_wr_o,
  input  logic [num_ro_regs_p*data_width_p-1:0]  ro_data_i
);

  localparam int idx_w_lp = addr_width_p - 2;

  function automatic axil_csr_decode_e csr_decode(input logic [idx_w_lp-1:0] idx);
    if (int'(idx) < num_rw_regs_p) return e_csr_rw;
    if (int'(idx) < num_rw_regs_p + num_ro_regs_p) return e_csr_ro;
    return e_csr_unmapped;
  endfunction

  logic                     aw_full_q, aw_full_d;
  logic [idx_w_lp-1:0]      aw_idx_q, aw_idx_d;
  logic                     w_full_q, w_full_d;
  logic [data_width_p-1:0]  wdata_q, wdata_d;
  logic [3:0]               wstrb_q, wstrb_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [data_width_p-1:0]  rw_q [num_rw_regs_p];
  logic [data_width_p-1:0]  rw_d [num_rw_regs_p];
  logic [num_rw_regs_p-1:0] rw_wr_q, rw_wr_d;
  logic                     rvalid_q, rvalid_d;
  logic [data_width_p-1:0]  rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs, commit;
  logic [idx_w_lp-1:0] rd_idx;
  axil_csr_decode_e wr_dec, rd_dec;

  // Protection bits and the byte offset carry no meaning for word-wide CSRs.
  logic unused_ok;
  assign unused_ok = ^{awprot_i, arprot_i, awaddr_i[1:0], araddr_i[1:0]};

  assign awready_o = ~reset_i & ~aw_full_q & ~bvalid_q;
  assign wready_o  = ~reset_i & ~w_full_q & ~bvalid_q;
  assign arready_o = ~reset_i & ~rvalid_q;
  assign aw_hs     = awvalid_i & awready_o;
  assign w_hs      = wvalid_i & wready_o;
  assign ar_hs     = arvalid_i & arready_o;
  assign commit    = aw_full_q & w_full_q;
  assign wr_dec    = csr_decode(aw_idx_q);
  assign rd_idx    = araddr_i[addr_width_p-1:2];
  assign rd_dec    = csr_decode(rd_idx);

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rw_wr_o  = rw_wr_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;

  for (genvar k = 0; k < num_rw_regs_p; k++) begin : g_rw_out
    assign rw_data_o[k*data_width_p +: data_width_p] = rw_q[k];
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rw_d      = rw_q;
    rw_wr_d   = '0;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr_i[addr_width_p-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if (bvalid_q && bready_i) bvalid_d = 1'b0;
    // Both halves held: retire the write and raise B on the same edge.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = axil_resp_slverr_gp;
      if (wr_dec == e_csr_rw) begin
        bresp_d = axil_resp_okay_gp;
        for (int k = 0; k < num_rw_regs_p; k++) begin
          if (int'(aw_idx_q) == k) begin
            rw_d[k]    = csr_byte_merge(rw_q[k], wdata_q, wstrb_q);
            rw_wr_d[k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rw_q      <= '{default: '0};
      rw_wr_q   <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rw_q      <= rw_d;
      rw_wr_q   <= rw_wr_d;
    end
  end

  // Reads sample rw_q before any same-edge commit, so they see the pre-write value.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && rready_i) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = axil_resp_slverr_gp;
      if (rd_dec == e_csr_rw) begin
        rresp_d = axil_resp_okay_gp;
        for (int k = 0; k < num_rw_regs_p; k++) begin
          if (int'(rd_idx) == k) rdata_d = rw_q[k];
        end
      end else if (rd_dec == e_csr_ro) begin
        rresp_d = axil_resp_okay_gp;
        for (int k = 0; k < num_ro_regs_p; k++) begin
          if (int'(rd_idx) == num_rw_regs_p + k) rdata_d = ro_data_i[k*data_width_p +: data_width_p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule
